bcd_display_engine: RTL

//  Sequential, parametrised binary-to-decimal display driver for the processor's output stage.

---
 rtl/display_pkg.sv | 31 +++
 rtl/seg7_encoder.sv | 33 +++
 rtl/bcd_display_engine.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/display_pkg.sv
// display_pkg: shared definitions for the BCD display engine.
//   - Seven-segment patterns (active-high, bit order a..g = [0]..[6]) for 0-9, dash, off.
//   - idig(width): scratch BCD nibble count for an iterative double-dabble on width+1 bits.
//   - state_e: conversion FSM states.
package display_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1101111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;
    localparam logic [6:0] SEG_OFF  = 7'b0000000;

    // Enough nibbles for the largest magnitude of width+1 bits.
    function automatic int unsigned idig(input int unsigned width);
        return (3 * width) / 10 + 2;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StShift,
        StFinish
    } state_e;

endpackage

// File: rtl/seg7_encoder.sv
// seg7_encoder: combinational BCD nibble to seven-segment pattern.
//   nibble  in   4  BCD digit; codes 10..15 map to unlit
//   pattern out  7  segments a..g = [0]..[6], polarity set by ACTIVE_LOW
module seg7_encoder
    import display_pkg::*;
#(
    parameter int unsigned ACTIVE_LOW = 1
) (
    input  logic [3:0] nibble,
    output logic [6:0] pattern
);

    logic [6:0] lit;

    always_comb begin
        lit = SEG_OFF;
        case (nibble)
            4'd0:    lit = SEG_0;
            4'd1:    lit = SEG_1;
            4'd2:    lit = SEG_2;
            4'd3:    lit = SEG_3;
            4'd4:    lit = SEG_4;
            4'd5:    lit = SEG_5;
            4'd6:    lit = SEG_6;
            4'd7:    lit = SEG_7;
            4'd8:    lit = SEG_8;
            4'd9:    lit = SEG_9;
            default: lit = SEG_OFF;
        endcase
        pattern = (ACTIVE_LOW != 0) ? ~lit : lit;
    end

endmodule

// File: rtl/bcd_display_engine.sv
// bcd_display_engine: sequential binary-to-decimal seven-segment driver.
// Accepts a WIDTH-bit value over valid/ready, converts one bit per cycle by
// double-dabble, then registers BCD digits, segments, overflow and sign flags.
//   clock, reset      rising-edge clock, synchronous active-high reset
//   in_valid/in_ready input handshake; ready only while idle
//   binary            value to display (two's complement when SIGNED=1)
//   segments          7*DIGITS, digit k at [7k+6:7k], k=0 is ones
//   bcd               4*DIGITS registered BCD magnitude, k=0 is ones
//   out_valid         one-cycle pulse when outputs update
//   overflow          result did not fit in DIGITS (sign included)
//   negative          result was negative (SIGNED=1 only)
module bcd_display_engine
    import display_pkg::*;
#(
    parameter int unsigned WIDTH       = 32,
    parameter int unsigned DIGITS      = 8,
    parameter int unsigned SIGNED      = 0,
    parameter int unsigned BLANK_ZEROS = 1,
    parameter int unsigned ACTIVE_LOW  = 1
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [WIDTH-1:0]      binary,
    output logic [7*DIGITS-1:0]   segments,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  out_valid,
    output logic                  overflow,
    output logic                  negative
);

    localparam int unsigned IDIG = idig(WIDTH);
    // Scratch view padded so every displayed digit has a nibble even when IDIG < DIGITS.
    localparam int unsigned EDIG = (IDIG > DIGITS) ? IDIG : DIGITS;
    localparam int unsigned CW   = $clog2(WIDTH + 1);

    localparam logic [6:0] PAT_DASH = (ACTIVE_LOW != 0) ? ~SEG_DASH : SEG_DASH;
    localparam logic [6:0] PAT_OFF  = (ACTIVE_LOW != 0) ? ~SEG_OFF : SEG_OFF;
    localparam logic [7*DIGITS-1:0] ALL_OFF = {DIGITS{PAT_OFF}};

    state_e             state_q, state_d;
    logic [CW-1:0]      count_q;
    logic [WIDTH-1:0]   mag_q;
    logic [4*IDIG-1:0]  scratch_q;
    logic               sign_q;

    logic               sign_in;
    logic [WIDTH-1:0]   mag_in;
    logic [4*IDIG-1:0]  adj;
    logic [4*EDIG-1:0]  bcd_ext;
    logic [7*DIGITS-1:0] enc_pat;
    logic [7*DIGITS-1:0] seg_next;
    logic               ovf;
    int unsigned        ms;
    int unsigned        sign_pos;

    // FSM state register
    always_ff @(posedge clock) begin
        if (reset) state_q <= StIdle;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        in_ready = 1'b0;
        case (state_q)
            StIdle: begin
                in_ready = ~reset;
                if (in_valid) state_d = StShift;
            end
            StShift:  if (count_q == CW'(1)) state_d = StFinish;
            StFinish: state_d = StIdle;
            default:  state_d = StIdle;
        endcase
    end

    // Input magnitude; negating in WIDTH bits is exact for -2^(WIDTH-1) read unsigned.
    always_comb begin
        sign_in = (SIGNED != 0) && binary[WIDTH-1];
        mag_in  = sign_in ? (WIDTH'(0) - binary) : binary;
    end

    // Add-3 correction applied before each shift.
    always_comb begin
        adj = scratch_q;
        for (int unsigned k = 0; k < IDIG; k++) begin
            if (scratch_q[4*k +: 4] >= 4'd5) adj[4*k +: 4] = scratch_q[4*k +: 4] + 4'd3;
        end
    end

    always_comb begin
        bcd_ext              = '0;
        bcd_ext[4*IDIG-1:0]  = scratch_q;
    end

    for (genvar k = 0; k < DIGITS; k++) begin : g_enc
        seg7_encoder #(
            .ACTIVE_LOW(ACTIVE_LOW)
        ) u_enc (
            .nibble (bcd_ext[4*k +: 4]),
            .pattern(enc_pat[7*k +: 7])
        );
    end

    // Blanking, sign placement and overflow from the finished scratch.
    always_comb begin
        ms  = 0;
        ovf = 1'b0;
        for (int unsigned k = 1; k < DIGITS; k++) begin
            if (bcd_ext[4*k +: 4] != 4'd0) ms = k;
        end
        for (int unsigned k = DIGITS; k < EDIG; k++) begin
            if (bcd_ext[4*k +: 4] != 4'd0) ovf = 1'b1;
        end
        // Sign needs a digit above the magnitude in either blanking mode.
        if (sign_q && (ms >= DIGITS - 1)) ovf = 1'b1;
        sign_pos = (BLANK_ZEROS != 0) ? ms + 1 : DIGITS - 1;
        seg_next = '0;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (ovf)                                  seg_next[7*k +: 7] = PAT_DASH;
            else if (sign_q && (k == sign_pos))       seg_next[7*k +: 7] = PAT_DASH;
            else if ((BLANK_ZEROS != 0) && (k > ms))  seg_next[7*k +: 7] = PAT_OFF;
            else                                      seg_next[7*k +: 7] = enc_pat[7*k +: 7];
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            count_q   <= '0;
            mag_q     <= '0;
            scratch_q <= '0;
            sign_q    <= 1'b0;
            segments  <= ALL_OFF;
            bcd       <= '0;
            out_valid <= 1'b0;
            overflow  <= 1'b0;
            negative  <= 1'b0;
        end else begin
            out_valid <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (in_valid) begin
                        scratch_q <= '0;
                        mag_q     <= mag_in;
                        sign_q    <= sign_in;
                        count_q   <= CW'(WIDTH);
                    end
                end
                StShift: begin
                    scratch_q <= {adj[4*IDIG-2:0], mag_q[WIDTH-1]};
                    mag_q     <= {mag_q[WIDTH-2:0], 1'b0};
                    count_q   <= count_q - 1'b1;
                end
                StFinish: begin
                    segments  <= seg_next;
                    bcd       <= bcd_ext[4*DIGITS-1:0];
                    overflow  <= ovf;
                    negative  <= sign_q;
                    out_valid <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule
